// File: rtl/cfu_initiator.sv
// rtl/cfu_initiator.sv - CFU command initiator with command/result FIFOs and response timeout
// Queues requests, issues them one at a time to the CFU and returns results in order.
module cfu_initiator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_timeout,
  output logic        busy,
  output logic [7:0]  timeout_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  state_t state, state_next;

  logic [73:0]   cmd_mem [DEPTH];
  logic [AW-1:0] cmd_wr, cmd_rd;
  logic [CW-1:0] cmd_count;
  logic [73:0]   cmd_head;
  logic          cmd_push, cmd_pop;

  logic [32:0]   res_mem [DEPTH];
  logic [AW-1:0] res_wr, res_rd;
  logic [CW-1:0] res_count;
  logic [32:0]   res_head;
  logic          res_push, res_pop, res_push_to;
  logic [31:0]   res_push_data;

  logic [7:0]    timer;
  logic          to_hit;

  assign req_ready = (cmd_count != CW'(DEPTH));
  assign cmd_push  = req_valid && req_ready;
  assign cmd_pop   = cmd_valid && cmd_ready;
  assign cmd_head  = cmd_mem[cmd_rd];
  assign cmd_payload_function_id = cmd_head[73:64];
  assign cmd_payload_inputs_1    = cmd_head[63:32];
  assign cmd_payload_inputs_0    = cmd_head[31:0];

  // Responses are always accepted; outside WAIT they are stale and simply dropped.
  assign rsp_ready = 1'b1;

  assign res_valid   = (res_count != '0);
  assign res_pop     = res_valid && res_ready;
  assign res_head    = res_mem[res_rd];
  assign res_data    = res_valid ? res_head[31:0] : 32'd0;
  assign res_timeout = res_valid ? res_head[32] : 1'b0;

  assign busy = (state != IDLE) || (cmd_count != '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cmd_valid     = 1'b0;
    res_push      = 1'b0;
    res_push_data = 32'd0;
    res_push_to   = 1'b0;
    to_hit        = 1'b0;
    case (state)
      // Issue only with a free result slot, so the single in-flight result always fits.
      IDLE: if (cmd_count != '0 && res_count != CW'(DEPTH)) state_next = ISSUE;
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_next = WAIT;
      end
      WAIT: begin
        if (rsp_valid) begin
          res_push      = 1'b1;
          res_push_data = rsp_payload_outputs_0;
          state_next    = IDLE;
        end else if (timer == 8'(TIMEOUT)) begin
          res_push      = 1'b1;
          res_push_data = 32'hDEADBEEF;
          res_push_to   = 1'b1;
          to_hit        = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer         <= 8'd0;
      timeout_count <= 8'd0;
    end else begin
      if (state == ISSUE)     timer <= 8'd0;
      else if (state == WAIT) timer <= timer + 8'd1;
      if (to_hit && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wr    <= '0;
      cmd_rd    <= '0;
      cmd_count <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem[cmd_wr] <= {req_function_id, req_inputs_1, req_inputs_0};
        cmd_wr          <= cmd_wr + AW'(1);
      end
      if (cmd_pop) cmd_rd <= cmd_rd + AW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + CW'(1);
        2'b01:   cmd_count <= cmd_count - CW'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_wr    <= '0;
      res_rd    <= '0;
      res_count <= '0;
    end else begin
      if (res_push) begin
        res_mem[res_wr] <= {res_push_to, res_push_data};
        res_wr          <= res_wr + AW'(1);
      end
      if (res_pop) res_rd <= res_rd + AW'(1);
      case ({res_push, res_pop})
        2'b10:   res_count <= res_count + CW'(1);
        2'b01:   res_count <= res_count - CW'(1);
        default: res_count <= res_count;
      endcase
    end
  end
endmodule

// File: tb/tb_cfu_initiator.sv
// tb/tb_cfu_initiator.sv - directed bench for cfu_initiator with a simple CFU model
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cfu_initiator;
  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        reset, req_valid, cmd_ready, rsp_valid, res_ready;
  logic        req_ready, cmd_valid, rsp_ready, res_valid, res_timeout, busy;
  logic [9:0]  req_function_id, cmd_payload_function_id;
  logic [31:0] req_inputs_0, req_inputs_1, cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic [31:0] rsp_payload_outputs_0, res_data;
  logic [7:0]  timeout_count;

  cfu_initiator #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_function_id(req_function_id),
    .req_inputs_0(req_inputs_0), .req_inputs_1(req_inputs_1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  fid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int rsp_delay = 1;
  int acc_count = 0;
  int acc_cyc = 0;
  logic [9:0]  last_fid;
  logic [31:0] last_a, last_b;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] cfu_f(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
    case (fid)
      10'd8:   return a + b;
      10'd1:   return a ^ b;
      10'd2:   return a - b;
      default: return a | b;
    endcase
  endfunction

  // CFU model: answers rsp_delay cycles after acceptance (0 = never).
  initial begin
    int cnt;
    logic pend;
    logic [31:0] val;
    cnt = 0; pend = 1'b0; val = '0;
    rsp_valid = 1'b0; rsp_payload_outputs_0 = '0;
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        pend = 1'b1; cnt = 0;
        val = cfu_f(cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1);
        last_fid = cmd_payload_function_id;
        last_a = cmd_payload_inputs_0;
        last_b = cmd_payload_inputs_1;
        acc_count = acc_count + 1;
        acc_cyc = cyc + 1;
      end
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      if (pend) begin
        cnt = cnt + 1;
        if (rsp_delay != 0 && cnt == rsp_delay) begin
          rsp_valid = 1'b1;
          rsp_payload_outputs_0 = val;
          pend = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input vec_t v);
    int g = 0;
    req_valid = 1'b1; req_function_id = v.fid; req_inputs_0 = v.a; req_inputs_1 = v.b;
    while (!req_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("push_wait_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic pop_result(input string name, input logic [31:0] exp_d, input logic exp_t);
    int g = 0;
    while (!res_valid && g < 200) begin @(negedge clk); g++; end
    chk({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({name, "_data"}, res_data, exp_d);
    chk({name, "_timeout"}, {31'd0, res_timeout}, {31'd0, exp_t});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int base, rc;
    tbl[0] = '{10'd8, 32'd3,          32'd5,          32'd8};
    tbl[1] = '{10'd1, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00};
    tbl[2] = '{10'd2, 32'd10,         32'd11,         32'hFFFF_FFFF};
    tbl[3] = '{10'd8, 32'hFFFF_FFFF,  32'd2,          32'd1};
    tbl[4] = '{10'd3, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678};
    tbl[5] = '{10'd1, 32'hDEAD_0000,  32'h0000_BEEF,  32'hDEAD_BEEF};

    reset = 1'b1; req_valid = 1'b0; req_function_id = '0; req_inputs_0 = '0; req_inputs_1 = '0;
    cmd_ready = 1'b1; res_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_timeout", {31'd0, res_timeout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_ready", {31'd0, rsp_ready}, 32'd1);
    chk("rst_timeout_count", {24'd0, timeout_count}, 32'd0);

    // Single requests through the table, one at a time.
    for (int i = 0; i < 6; i++) begin
      base = acc_count;
      push(tbl[i]);
      pop_result($sformatf("single%0d", i), tbl[i].exp, 1'b0);
      chk($sformatf("single%0d_issues", i), acc_count - base, 32'd1);
      chk($sformatf("single%0d_fid", i), {22'd0, last_fid}, {22'd0, tbl[i].fid});
      chk($sformatf("single%0d_in0", i), last_a, tbl[i].a);
      chk($sformatf("single%0d_in1", i), last_b, tbl[i].b);
      chk($sformatf("single%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // Command FIFO full with the CFU stalled.
    cmd_ready = 1'b0;
    base = acc_count;
    for (int i = 0; i < 4; i++) push(tbl[i]);
    chk("full_req_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1; req_function_id = tbl[4].fid; req_inputs_0 = tbl[4].a; req_inputs_1 = tbl[4].b;
    idle(3);
    chk("full_req_ready_held", {31'd0, req_ready}, 32'd0);
    chk("full_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    chk("full_head_fid", {22'd0, cmd_payload_function_id}, {22'd0, tbl[0].fid});
    chk("full_head_in0", cmd_payload_inputs_0, tbl[0].a);
    chk("full_no_issue", acc_count - base, 32'd0);
    req_valid = 1'b0;
    cmd_ready = 1'b1;
    push(tbl[4]);
    for (int i = 0; i < 5; i++) pop_result($sformatf("order%0d", i), tbl[i].exp, 1'b0);

    // Result FIFO back-pressure.
    base = acc_count;
    for (int i = 0; i < 6; i++) push(tbl[i]);
    idle(20);
    chk("resfull_issued", acc_count - base, 32'd4);
    chk("resfull_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("resfull_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 6; i++) pop_result($sformatf("drain%0d", i), tbl[i].exp, 1'b0);
    chk("drain_issued", acc_count - base, 32'd6);

    // Late response: timeout result, then the stray response is dropped.
    rsp_delay = 14;
    push(tbl[0]);
    rc = 0;
    while (!res_valid && rc < 100) begin @(negedge clk); rc++; end
    chk("to_latency", cyc - acc_cyc, TO + 1);
    idle(6);
    pop_result("to_res", 32'hDEADBEEF, 1'b1);
    chk("to_count", {24'd0, timeout_count}, 32'd1);
    chk("to_stray_dropped", {31'd0, res_valid}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);

    // Response exactly at timer == TIMEOUT wins; one cycle later it loses.
    rsp_delay = TO + 1;
    push(tbl[1]);
    pop_result("edge_rsp", tbl[1].exp, 1'b0);
    chk("edge_count", {24'd0, timeout_count}, 32'd1);
    rsp_delay = TO + 2;
    push(tbl[2]);
    pop_result("edge_late", 32'hDEADBEEF, 1'b1);
    chk("edge_late_count", {24'd0, timeout_count}, 32'd2);
    idle(4);
    chk("edge_late_stray", {31'd0, res_valid}, 32'd0);

    // Reset during WAIT with two queued commands.
    rsp_delay = 0;
    base = acc_count;
    for (int i = 0; i < 3; i++) push(tbl[i]);
    idle(3);
    chk("rstw_in_wait", acc_count - base, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rstw_timeout_count", {24'd0, timeout_count}, 32'd0);
    idle(20);
    chk("rstw_no_result", {31'd0, res_valid}, 32'd0);
    chk("rstw_no_issue", acc_count - base, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
